// File: rtl/line_rows3_feeder.sv
// Raster-to-three-row feeder for a 3x3 window: two line memories supply the
// pixels one and two rows above the incoming pixel, aligned by column.
module line_rows3_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      sof_in,
  input  logic [DATA_WIDTH-1:0]     pix_in,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     pix_curr,
  output logic [DATA_WIDTH-1:0]     pix_m1,
  output logic [DATA_WIDTH-1:0]     pix_m2,
  output logic [$clog2(WIDTH)-1:0]  out_col,
  output logic [$clog2(HEIGHT)-1:0] out_row,
  output logic                      out_eol,
  output logic                      out_eof,
  output logic                      sync_err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  logic [DATA_WIDTH-1:0] lbuf_a [WIDTH];
  logic [DATA_WIDTH-1:0] lbuf_b [WIDTH];

  logic [CW-1:0]         col_cnt, c;
  logic [RW-1:0]         row_cnt, r;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic                  emit, at_origin;

  // sof_in forces the effective position to the frame origin
  always_comb begin
    c         = sof_in ? '0 : col_cnt;
    r         = sof_in ? '0 : row_cnt;
    rd_a      = lbuf_a[c];
    rd_b      = lbuf_b[c];
    emit      = in_valid && (r >= ROW_FIRST);
    at_origin = (col_cnt == '0) && (row_cnt == '0);
  end

  // Read-first: the reads above see the old contents; the writes land at the edge
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lbuf_a[c] <= pix_in;
      lbuf_b[c] <= rd_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      pix_curr  <= '0;
      pix_m1    <= '0;
      pix_m2    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= emit;
      out_eol   <= emit && (c == COL_LAST);
      out_eof   <= emit && (c == COL_LAST) && (r == ROW_LAST);
      sync_err  <= in_valid && sof_in && !at_origin;
      if (emit) begin
        pix_curr <= pix_in;
        pix_m1   <= rd_a;
        pix_m2   <= rd_b;
        out_col  <= c;
        out_row  <= r;
      end
      if (in_valid) begin
        if (c == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (r == ROW_LAST) ? '0 : r + 1'b1;
        end else begin
          col_cnt <= c + 1'b1;
          row_cnt <= r;
        end
      end
    end
  end

endmodule
